// File: rtl/ring_conf_ctrl.sv
// ring_conf_ctrl: collects per-cluster ring reconfiguration requests, drains in-flight flits, applies to all routers.
// Optional collect-phase timeout enabled by RING_CONF_CTRL_TIMEOUT_EN.
module ring_conf_ctrl #(
  parameter int NrClusters    = 4,
  parameter int CntWidth      = 8,
  parameter int TimeoutCycles = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NrClusters-1:0] sldu_conf_valid_i,
  input  logic [NrClusters-1:0] sldu_dir_i,
  input  logic [NrClusters-1:0] sldu_bypass_i,
  input  logic [NrClusters-1:0] inject_i,
  input  logic [NrClusters-1:0] eject_i,
  output logic [NrClusters-1:0] router_dir_o,
  output logic [NrClusters-1:0] router_bypass_o,
  output logic [NrClusters-1:0] router_conf_valid_o,
  output logic                  conf_ack_o,
  output logic                  busy_o,
  output logic                  mismatch_o,
  output logic                  cnt_err_o,
  output logic                  timeout_o
);
  localparam int W = CntWidth + 6;
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, APPLY} state_e;
  state_e state_q, state_d;
  logic [NrClusters-1:0] pend_q, pend_d, dir_q, dir_d, byp_q, byp_d, take;
  logic [NrClusters-1:0] rdir_q, rbyp_q, rcv_q;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [W-1:0] up, dec, diff;
  logic under, over, ack_q, mis_q, mis_d, err_q, err_d;
  // Counter math is done wide so both saturation directions are detectable.
  assign up    = W'(cnt_q) + W'($countones(inject_i));
  assign dec   = W'($countones(eject_i));
  assign diff  = up - dec;
  assign under = dec > up;
  assign over  = !under && diff > W'({CntWidth{1'b1}});
  assign cnt_d = under ? '0 : over ? '1 : diff[CntWidth-1:0];
  assign err_d = err_q | under | over;
  assign take  = (state_q == IDLE || state_q == COLLECT) ? sldu_conf_valid_i & ~pend_q : '0;
  assign dir_d = (dir_q & ~take) | (sldu_dir_i & take);
  assign byp_d = (byp_q & ~take) | (sldu_bypass_i & take);
`ifdef RING_CONF_CTRL_TIMEOUT_EN
  localparam int TmoW = $clog2(TimeoutCycles + 1);
  logic [TmoW-1:0] tmo_q;
  logic to_d, to_q;
  always_ff @(posedge clk_i)
    if (!rst_ni) tmo_q <= '0;
    else tmo_q <= (state_q == COLLECT && state_d == COLLECT) ? tmo_q + 1'b1 : '0;
  always_ff @(posedge clk_i)
    if (!rst_ni) to_q <= 1'b0;
    else to_q <= to_d;
  assign timeout_o = to_q;
`else
  assign timeout_o = (TimeoutCycles < 0);
`endif
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q | take;
    mis_d   = mis_q;
`ifdef RING_CONF_CTRL_TIMEOUT_EN
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE, COLLECT: begin
        if (&pend_d) begin
          if (dir_d == '0 || &dir_d) state_d = DRAIN;
          else begin
            state_d = IDLE;
            pend_d  = '0;
            mis_d   = 1'b1;
          end
        end else if (|pend_d) begin
          state_d = COLLECT;
`ifdef RING_CONF_CTRL_TIMEOUT_EN
          if (state_q == COLLECT && tmo_q == TmoW'(TimeoutCycles - 1)) begin
            state_d = IDLE;
            pend_d  = '0;
            to_d    = 1'b1;
          end
`endif
        end
      end
      DRAIN: state_d = (cnt_q == '0 && inject_i == '0) ? APPLY : DRAIN;
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pend_q  <= '0;
      dir_q   <= '0;
      byp_q   <= '0;
      cnt_q   <= '0;
      rdir_q  <= '0;
      rbyp_q  <= '0;
      rcv_q   <= '0;
      ack_q   <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      byp_q   <= byp_d;
      cnt_q   <= cnt_d;
      rcv_q   <= {NrClusters{state_d == APPLY}};
      ack_q   <= state_d == APPLY;
      mis_q   <= mis_d;
      err_q   <= err_d;
      if (state_d == APPLY) begin
        rdir_q <= dir_q;
        rbyp_q <= byp_q;
      end
    end
  end
  assign router_dir_o        = rdir_q;
  assign router_bypass_o     = rbyp_q;
  assign router_conf_valid_o = rcv_q;
  assign conf_ack_o          = ack_q;
  assign busy_o              = state_q != IDLE;
  assign mismatch_o          = mis_q;
  assign cnt_err_o           = err_q;
endmodule

// File: tb/tb_ring_conf_ctrl.sv
// tb_ring_conf_ctrl: directed scenarios plus random traffic checked against a behavioural model.
module tb_ring_conf_ctrl;
  localparam int N = 4, CW = 8, TC = 16, MAXC = (1 << CW) - 1;
`ifdef RING_CONF_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int P_IDLE = 0, P_COLLECT = 1, P_DRAIN = 2, P_APPLY = 3;
  logic clk = 1'b0, rst_n;
  logic [N-1:0] vld, dir, byp, inj, ej;
  logic [N-1:0] r_dir, r_byp, r_cv;
  logic ack, busy, mis, cerr, tmo;
  int checks = 0, errors = 0;
  int phase, inflight, waited;
  bit seen [N];
  bit s_dir [N];
  bit s_byp [N];
  bit m_mis, m_err, m_to;
  logic [N-1:0] m_rdir, m_rbyp;

  ring_conf_ctrl #(.NrClusters(N), .CntWidth(CW), .TimeoutCycles(TC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sldu_conf_valid_i(vld), .sldu_dir_i(dir),
    .sldu_bypass_i(byp), .inject_i(inj), .eject_i(ej), .router_dir_o(r_dir),
    .router_bypass_o(r_byp), .router_conf_valid_o(r_cv), .conf_ack_o(ack),
    .busy_o(busy), .mismatch_o(mis), .cnt_err_o(cerr), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic forget_requests();
    for (int i = 0; i < N; i++) seen[i] = 1'b0;
  endtask

  task automatic model_edge();
    int level, n, ones;
    if (!rst_n) begin
      phase = P_IDLE; inflight = 0; waited = 0;
      m_mis = 0; m_err = 0; m_to = 0; m_rdir = '0; m_rbyp = '0;
      forget_requests();
      return;
    end
    level = inflight + $countones(inj) - $countones(ej);
    if (level > MAXC) begin level = MAXC; m_err = 1; end
    if (level < 0) begin level = 0; m_err = 1; end
    m_to = 0;
    if (phase == P_APPLY) begin
      phase = P_IDLE;
      forget_requests();
    end else if (phase == P_DRAIN) begin
      if (inflight == 0 && inj == '0) begin
        phase = P_APPLY;
        for (int i = 0; i < N; i++) begin m_rdir[i] = s_dir[i]; m_rbyp[i] = s_byp[i]; end
      end
    end else begin
      n = 0; ones = 0;
      for (int i = 0; i < N; i++)
        if (vld[i] && !seen[i]) begin seen[i] = 1; s_dir[i] = dir[i]; s_byp[i] = byp[i]; end
      for (int i = 0; i < N; i++) begin n += int'(seen[i]); ones += int'(seen[i] && s_dir[i]); end
      if (n == N) begin
        waited = 0;
        if (ones == 0 || ones == N) phase = P_DRAIN;
        else begin m_mis = 1; forget_requests(); phase = P_IDLE; end
      end else if (n > 0) begin
        waited = (phase == P_COLLECT) ? waited + 1 : 0;
        phase = P_COLLECT;
        if (TO_EN && waited == TC) begin
          m_to = 1; waited = 0; forget_requests(); phase = P_IDLE;
        end
      end
    end
    inflight = level;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("conf_valid", r_cv, {N{phase == P_APPLY}});
    check("conf_ack", ack, phase == P_APPLY);
    check("router_dir", r_dir, m_rdir);
    check("router_bypass", r_byp, m_rbyp);
    check("busy", busy, phase != P_IDLE);
    check("mismatch", mis, m_mis);
    check("cnt_err", cerr, m_err);
    check("timeout", tmo, m_to);
  endtask

  initial begin
    logic [N-1:0] sess;
    vld = '0; dir = '0; byp = '0; inj = '0; ej = '0; rst_n = 1'b0;
    repeat (2) step();
    check("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    // all four together, counter idle
    vld = '1; dir = '1; byp = '0; step();
    vld = '0;
    check("all_busy", busy, 1'b1);
    step();
    check("all_cv", r_cv, 4'hF);
    check("all_dir", r_dir, 4'hF);
    check("all_ack", ack, 1'b1);
    step();
    check("all_ack_end", ack, 1'b0);
    check("all_idle", busy, 1'b0);
    // staggered arrivals
    dir = '0; byp = 4'b0101;
    for (int c = 0; c < 10; c++) begin
      vld = (c == 0) ? 4'b0001 : (c == 3) ? 4'b0010 : (c == 5) ? 4'b0100 : (c == 9) ? 4'b1000 : 4'b0000;
      step();
      if (c < 9) check("stag_nopulse", r_cv, 4'h0);
    end
    vld = '0; step();
    check("stag_cv", r_cv, 4'hF);
    check("stag_dir", r_dir, 4'h0);
    check("stag_byp", r_byp, 4'b0101);
    step();
    // drain with three flits in flight
    inj = 4'b0111; step();
    inj = '0; vld = '1; dir = '1; byp = 4'b0011; step();
    vld = '0;
    for (int k = 0; k < 3; k++) begin
      ej = 4'b0001; step();
      check("drain_hold", busy, 1'b1);
      check("drain_nopulse", r_cv, 4'h0);
    end
    ej = '0; step();
    check("drain_cv", r_cv, 4'hF);
    step();
    check("drain_once", r_cv, 4'h0);
    // direction disagreement
    vld = '1; dir = 4'b1011; step();
    vld = '0;
    check("mis_flag", mis, 1'b1);
    check("mis_idle", busy, 1'b0);
    step();
    check("mis_sticky", mis, 1'b1);
    check("mis_dir_kept", r_dir, 4'hF);
    // underflow, then reset in the middle of a drain
    ej = 4'b0001; step();
    ej = '0;
    check("underflow_err", cerr, 1'b1);
    inj = 4'b0011; vld = '1; dir = '0; step();
    inj = '0; vld = '0; step();
    check("mid_drain_busy", busy, 1'b1);
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_mis", mis, 1'b0);
    check("rst_err", cerr, 1'b0);
    step();
    check("rst_nopulse", r_cv, 4'h0);
    // lone requester in collect
    vld = 4'b0001; dir = '1; step();
    vld = '0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == TC) check("collect_timeout", tmo, TO_EN);
    end
    check("collect_busy", busy, !TO_EN);
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    // counter overflow saturates
    inj = '1;
    repeat (70) step();
    inj = '0;
    check("overflow_err", cerr, 1'b1);
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    // random traffic
    sess = '1;
    for (int k = 0; k < 4000; k++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 19) == 0) sess = ~sess;
      for (int i = 0; i < N; i++) begin
        vld[i] = ($urandom_range(0, 3) == 0);
        dir[i] = sess[i] ^ ($urandom_range(0, 15) == 0);
        byp[i] = 1'($urandom_range(0, 1));
        inj[i] = ($urandom_range(0, 9) == 0);
        ej[i]  = ($urandom_range(0, 9) == 0);
      end
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
